// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial add/subtract sequencer.
package add_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice counter width; never narrower than one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request/result bundle between a requester and the add/subtract sequencer.
interface add_seq_ctrl_if
    import add_seq_pkg::*;
#(
    parameter int NSLICE = 4
);
    localparam int W = SLICE_W * NSLICE;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, s, co, ovf
    );

endinterface

// File: rtl/add_seq_ctrl_fa4_slice.sv
// Combinational 4-bit ripple-carry adder slice, time-shared by the sequencer.
module fa4_slice
    import add_seq_pkg::*;
(
    output logic [SLICE_W-1:0] s,
    output logic               co,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[SLICE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer: one nibble per clock through a single 4-bit slice,
// carry held in a register between slices, one-cycle done pulse on completion.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int NSLICE = 4
)(
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus
);

    localparam int             W      = SLICE_W * NSLICE;
    localparam int             KW     = cnt_width(NSLICE);
    localparam logic [KW-1:0]  K_LAST = KW'(NSLICE - 1);

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [W-1:0]        a_q, b_q;
    logic [W-1:0]        s_q, s_d;
    logic                carry_q, co_q, ovf_q, busy_q, done_q;
    logic                load, step, last;

    logic [SLICE_W-1:0]  a_nib [NSLICE];
    logic [SLICE_W-1:0]  b_nib [NSLICE];
    logic [SLICE_W-1:0]  slice_s;
    logic                slice_co;
    logic                ovf_d;

    // Operand nibble views and the per-nibble result update.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_nib
            assign a_nib[gi] = a_q[gi*SLICE_W +: SLICE_W];
            assign b_nib[gi] = b_q[gi*SLICE_W +: SLICE_W];
            assign s_d[gi*SLICE_W +: SLICE_W] =
                load                              ? '0      :
                (step && (k_q == KW'(gi)))        ? slice_s :
                                                    s_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    fa4_slice u_slice (
        .s  (slice_s),
        .co (slice_co),
        .a  (a_nib[k_q]),
        .b  (b_nib[k_q]),
        .ci (carry_q)
    );

    assign last  = (k_q == K_LAST);
    // Carry into the MSB xor carry out of it.
    assign ovf_d = a_q[W-1] ^ b_q[W-1] ^ slice_s[SLICE_W-1] ^ slice_co;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
            s_q     <= s_d;
            if (load) begin
                // Subtract is a + ~b + 1, so the incoming carry is forced high.
                a_q     <= bus.a;
                b_q     <= bus.sub ? ~bus.b : bus.b;
                carry_q <= bus.sub | bus.ci;
                k_q     <= '0;
                co_q    <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (step) begin
                carry_q <= slice_co;
                k_q     <= last ? '0 : k_q + 1'b1;
                if (last) begin
                    co_q  <= slice_co;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed literal cases plus randomized traffic against a
// transaction-level arithmetic model checked every cycle.
module tb_add_seq_ctrl;
    import add_seq_pkg::*;

    localparam int NSLICE = 4;
    localparam int W      = SLICE_W * NSLICE;

    logic clk = 1'b0;
    logic rst = 1'b1;

    add_seq_ctrl_if #(.NSLICE(NSLICE)) bus ();

    add_seq_ctrl #(.NSLICE(NSLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ops = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference arithmetic from signed/unsigned integer values.
    function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit ci, input bit sub,
                                   output logic [W-1:0] s, output bit co, output bit ovf);
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= (64'sd1 <<< (W-1))) ? ua - (64'sd1 <<< W) : ua;
        sb = (ub >= (64'sd1 <<< (W-1))) ? ub - (64'sd1 <<< W) : ub;
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + longint'(ci);
            sr = sa + sb + longint'(ci);
            co = (ur >= (64'sd1 <<< W));
        end
        s   = W'(ur);
        ovf = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
    endfunction

    // Model state: expected outputs after each rising edge.
    bit           chk_en = 1'b0;
    bit           m_busy, m_done, m_co, m_ovf, s_known;
    logic [W-1:0] m_s, p_s, p_a, p_b;
    bit           p_co, p_ovf, p_ci, p_sub;
    int           remain;

    always @(posedge clk) begin
        if (rst) begin
            chk_en  = 1'b1;
            m_busy  = 0; m_done = 0; m_co = 0; m_ovf = 0;
            m_s     = '0; s_known = 1; remain = 0;
        end else if (chk_en) begin
            if (bus.start && !m_busy) begin
                p_a = bus.a; p_b = bus.b; p_ci = bus.ci; p_sub = bus.sub;
                ref_op(bus.a, bus.b, bus.ci, bus.sub, p_s, p_co, p_ovf);
                remain  = NSLICE;
                m_busy  = 1; m_done = 0; m_co = 0; m_ovf = 0; s_known = 0;
            end else if (m_busy) begin
                remain--;
                if (remain == 0) begin
                    m_busy = 0; m_done = 1;
                    m_s = p_s; m_co = p_co; m_ovf = p_ovf; s_known = 1;
                    n_ops++;
                    $display("op %0d: a=%h b=%h ci=%0d sub=%0d -> s=%h co=%0d ovf=%0d",
                             n_ops, p_a, p_b, p_ci, p_sub, p_s, p_co, p_ovf);
                end
            end else begin
                m_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("co",   32'(bus.co),   32'(m_co));
            chk("ovf",  32'(bus.ovf),  32'(m_ovf));
            if (s_known) chk("s", 32'(bus.s), 32'(m_s));
        end
    end

    // Called at a negedge; returns at the next negedge with start released.
    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit ci, input bit sub);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int cnt, output int bcnt);
        cnt  = 0;
        bcnt = 0;
        while (!bus.done && cnt < 30) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            cnt++;
        end
        if (!bus.done) begin
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 30 cycles", nm);
        end
    endtask

    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit ci, input bit sub,
                      input logic [W-1:0] es, input bit eco, input bit eovf);
        int cnt, bcnt;
        pulse_start(a, b, ci, sub);
        wait_done(nm, cnt, bcnt);
        chk({nm, "_lat"},  32'(cnt),    32'd4);
        chk({nm, "_busy"}, 32'(bcnt),   32'd4);
        chk({nm, "_s"},    32'(bus.s),  32'(es));
        chk({nm, "_co"},   32'(bus.co), 32'(eco));
        chk({nm, "_ovf"},  32'(bus.ovf), 32'(eovf));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cnt, bcnt, ndone;
        logic [W-1:0] corner [4];
        corner[0] = 16'hFFFF; corner[1] = 16'h0000; corner[2] = 16'h8000; corner[3] = 16'h7FFF;

        bus.start = 0; bus.a = '0; bus.b = '0; bus.ci = 0; bus.sub = 0;
        repeat (2) @(negedge clk);
        chk("rst_s",    32'(bus.s),    32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("add_basic", 16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
        op("ripple",    16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        op("ripple_ci", 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 1, 0);
        op("sovf",      16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        op("sub_neg",   16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
        op("sub_pos",   16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0);

        // Start pulse two cycles into RUN must be ignored.
        pulse_start(16'h1234, 16'h1111, 0, 0);
        @(negedge clk);
        pulse_start(16'hAAAA, 16'h5555, 1, 1);
        wait_done("ign", cnt, bcnt);
        chk("ign_s", 32'(bus.s), 32'h2345);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("ign_ndone", 32'(ndone), 32'd0);

        // Back-to-back: start during the done cycle.
        pulse_start(16'h0100, 16'h0200, 0, 0);
        wait_done("b2b_a", cnt, bcnt);
        chk("b2b_a_s", 32'(bus.s), 32'h0300);
        pulse_start(16'h0010, 16'h0001, 0, 1);
        wait_done("b2b_b", cnt, bcnt);
        chk("b2b_gap", 32'(cnt + 1), 32'd5);
        chk("b2b_b_s", 32'(bus.s), 32'h000F);
        repeat (2) @(negedge clk);

        // Reset while k=2.
        pulse_start(16'h7FFF, 16'h7FFF, 1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_s",    32'(bus.s),    32'd0);
        chk("mrst_co",   32'(bus.co),   32'd0);
        chk("mrst_ovf",  32'(bus.ovf),  32'd0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mrst_stray", 32'(ndone), 32'd0);
        op("post_rst", 16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 2000; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            bus.b     = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            bus.ci    = 1'($urandom);
            bus.sub   = 1'($urandom);
            rst       = ($urandom_range(0, 80) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-cycle sequencer that performs a wide add or subtract by time-sharing a single 4-bit ripple adder slice. It captures operands on a `start` request, feeds the slice one nibble per clock from LSB to MSB, and holds the carry between cycles. It raises a one-cycle `done` pulse when the full-width result is valid. It sits between a requester (control FSM or testbench) and the 4-bit adder datapath, trading latency for area.

## Interface
- `NSLICE`, default 4: number of 4-bit slices. Operand width W = 4*NSLICE, so the default is 16 bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  0 = add (a+b+ci), 1 = subtract (a-b, ci ignored).
- `a`  in  W  operand A, captured with `start`.
- `b`  in  W  operand B, captured with `start`.
- `ci`  in  1  carry-in for add, captured with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; result valid.
- `s`  out  W  result register.
- `co`  out  1  carry out of MSB; for subtract, 1 means no borrow.
- `ovf`  out  1  two's-complement overflow.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: one slice computed per cycle.
  - DONE: single cycle, `done`=1.
- IDLE, `start`=1:
  - Capture `a`, `b`, `sub`.
  - Load b_r = `sub` ? ~b : b.
  - Load carry_r = `sub` ? 1 : ci.
  - Clear slice counter k to 0, clear `s`, go to RUN.
- RUN, each cycle:
  - Slice inputs: a_r[4k+3:4k], b_r[4k+3:4k], carry_r.
  - Write the slice sum into s[4k+3:4k]; carry_r <= slice carry.
  - If k = NSLICE-1: go to DONE, else k <= k+1.
- On the last slice:
  - co <= slice carry.
  - ovf <= a_r[W-1] ^ b_r[W-1] ^ s_slice[3] ^ slice carry (carry into MSB xor carry out).
- DONE:
  - `start`=1 is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- `start` during RUN is ignored; captured operands are unaffected.
- `s` may show partial nibbles during RUN. It is defined only while `done`=1, and is then held (with `co`, `ovf`) until the next accepted `start`.
- `co` and `ovf` are cleared when a `start` is accepted.
- Arithmetic is modulo 2^W; no saturation.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `s`=0, `co`=0, `ovf`=0, k=0, carry_r=0.
- `rst` has priority over all other inputs in any state, including mid-RUN. The operation is abandoned and no `done` is issued.
- Latency:
  - `start` sampled at edge t.
  - `busy`=1 from edge t through edge t+NSLICE.
  - `done`=1 for exactly the cycle after edge t+NSLICE (4 cycles after capture by default).
- Throughput: one operation per NSLICE+1 cycles with back-to-back `start`s.
- `done` and `busy` are never high together.
- All outputs are registered.

## Structure
- Package `add_seq_pkg`:
  - SLICE_W = 4.
  - State enum {IDLE, RUN, DONE}.
- Sub-module `fa4_slice`: purely combinational 4-bit ripple adder with ports s[3:0], co, a[3:0], b[3:0], ci. Instantiated once.
- Counter width is $clog2(NSLICE), minimum 1.
- Nibble select, carry register and FSM live in `add_seq_ctrl`.

## Test plan
All scenarios use NSLICE=4.
- Basic add: a=16'h1234, b=16'h4321, ci=0, sub=0 -> s=16'h5555, co=0, ovf=0; `done` exactly 4 cycles after the start edge, `busy` high 4 cycles.
- Full ripple: a=16'hFFFF, b=16'h0001, ci=0 -> s=16'h0000, co=1, ovf=0. With ci=1 and a=16'hFFFF, b=0 -> s=0, co=1.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> s=16'h8000, co=0, ovf=1.
- Subtract: sub=1, a=16'h0005, b=16'h0007, ci=1 (ignored) -> s=16'hFFFE, co=0, ovf=0. Then a=16'h0007, b=16'h0005 -> s=16'h0002, co=1.
- Handshake:
  - Pulse `start` with new operands 2 cycles into RUN -> ignored, first result unchanged, single `done`.
  - `start` asserted during the `done` cycle -> accepted, second `done` exactly 5 cycles after the first.
- Reset mid-operation: assert `rst` for 1 cycle at RUN k=2 -> next cycle `busy`=0, `done`=0, `s`=0, `co`=0, `ovf`=0, no stray `done` afterwards. A following add of 16'h0001+16'h0001 gives s=16'h0002.
